// File: rtl/exec_pkg.sv
// Shared encodings and the registered-state layout for the execute stage.
package exec_pkg;
    localparam int XLEN = 32;

    // ALU sub-ops (funct3)
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Branch compares (funct3)
    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    typedef struct packed {
        logic [XLEN-1:0] fetch_pc;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] op2;
        logic            mem_write;
        logic            mem_to_reg;
        logic            alu_to_reg;
        logic [4:0]      dest;
        logic [2:0]      funct3;
        logic            bubble;
        logic [XLEN-1:0] next_pc;
        logic            taken;
        logic            squash;
    } ex_state_t;
endpackage

// File: rtl/execute_alu.sv
// Combinational ALU plus branch comparator for the execute stage.
module execute_alu
    import exec_pkg::*;
(
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [2:0]      funct3_i,
    input  logic            alt_i,
    output logic [XLEN-1:0] result_o,
    output logic            cond_o
);
    logic [4:0] shamt;
    logic       lt_s, lt_u;

    assign shamt = op2_i[4:0];
    assign lt_s  = $signed(op1_i) < $signed(op2_i);
    assign lt_u  = op1_i < op2_i;

    always_comb begin
        result_o = '0;
        case (funct3_i)
            F3_ADD:  result_o = alt_i ? op1_i - op2_i : op1_i + op2_i;
            F3_SLL:  result_o = op1_i << shamt;
            F3_SLT:  result_o = {{(XLEN-1){1'b0}}, lt_s};
            F3_SLTU: result_o = {{(XLEN-1){1'b0}}, lt_u};
            F3_XOR:  result_o = op1_i ^ op2_i;
            F3_SR:   result_o = alt_i ? $unsigned($signed(op1_i) >>> shamt) : op1_i >> shamt;
            F3_OR:   result_o = op1_i | op2_i;
            F3_AND:  result_o = op1_i & op2_i;
            default: result_o = '0;
        endcase
    end

    always_comb begin
        cond_o = 1'b0;
        case (funct3_i)
            BR_EQ:   cond_o = (op1_i == op2_i);
            BR_NE:   cond_o = (op1_i != op2_i);
            BR_LT:   cond_o = lt_s;
            BR_GE:   cond_o = !lt_s;
            BR_LTU:  cond_o = lt_u;
            BR_GEU:  cond_o = !lt_u;
            default: cond_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/execute.sv
// Execute stage: forwarding, ALU, branch resolution, wb pipeline registers and
// the one-slot squash after a redirect.
module execute
    import exec_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_i,
    input  logic            valid_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [4:0]      rs1_i,
    input  logic [4:0]      rs2_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [2:0]      funct3_i,
    input  logic            alt_i,
    input  logic            imm_sel_i,
    input  logic            lui_i,
    input  logic            auipc_i,
    input  logic            jal_i,
    input  logic            jalr_i,
    input  logic            branch_i,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic [4:0]      dest_i,
    input  logic            fwd_we_i,
    input  logic [4:0]      fwd_dest_i,
    input  logic [XLEN-1:0] fwd_data_i,
    output logic [XLEN-1:0] fetch_pc_o,
    output logic [XLEN-1:0] write_address_o,
    output logic [XLEN-1:0] alu_operand2_o,
    output logic            mem_write_o,
    output logic            wb_mem_to_reg_o,
    output logic            wb_alu_to_reg_o,
    output logic [4:0]      wb_dest_o,
    output logic [1:0]      wb_read_address_o,
    output logic [2:0]      wb_alu_operation_o,
    output logic            wb_branch_o,
    output logic [XLEN-1:0] next_pc_o,
    output logic            branch_taken_o,
    output logic            branch_stall_o
);
    ex_state_t       st_q, st_d;
    logic [XLEN-1:0] rs1f, rs2f, op1, op2, alu_res, result, target, pc_plus4;
    logic [2:0]      alu_f3;
    logic            alu_alt, force_add, cond, taken, redirect, accept;

    assign rs1f = (fwd_we_i && fwd_dest_i == rs1_i && rs1_i != 5'd0) ? fwd_data_i : rs1_data_i;
    assign rs2f = (fwd_we_i && fwd_dest_i == rs2_i && rs2_i != 5'd0) ? fwd_data_i : rs2_data_i;
    assign op1  = (auipc_i || jal_i) ? pc_i : (lui_i ? '0 : rs1f);
    assign op2  = imm_sel_i ? imm_i : rs2f;

    // Address and upper-immediate ops always add; their funct3 carries width/imm bits.
    assign force_add = mem_read_i || mem_write_i || lui_i || auipc_i;
    assign alu_f3    = force_add ? F3_ADD : funct3_i;
    assign alu_alt   = force_add ? 1'b0 : alt_i;

    execute_alu u_alu (
        .op1_i    (op1),
        .op2_i    (op2),
        .funct3_i (alu_f3),
        .alt_i    (alu_alt),
        .result_o (alu_res),
        .cond_o   (cond)
    );

    assign pc_plus4 = pc_i + 32'd4;
    assign result   = (jal_i || jalr_i) ? pc_plus4 : alu_res;
    assign target   = jalr_i ? ((rs1f + imm_i) & ~32'h1) : (pc_i + imm_i);
    assign taken    = branch_i && cond;
    assign redirect = taken || jal_i || jalr_i;
    assign accept   = valid_i && !stall_i && !st_q.squash;

    always_comb begin
        st_d = st_q;
        if (!stall_i) begin
            // Default is a bubble; it is marked as squashed only when closing a redirect window.
            st_d.mem_write  = 1'b0;
            st_d.mem_to_reg = 1'b0;
            st_d.alu_to_reg = 1'b0;
            st_d.taken      = 1'b0;
            st_d.squash     = 1'b0;
            st_d.bubble     = st_q.squash;
            if (accept) begin
                st_d.fetch_pc   = pc_i;
                st_d.addr       = result;
                st_d.op2        = rs2f;
                st_d.mem_write  = mem_write_i;
                st_d.mem_to_reg = mem_read_i;
                st_d.alu_to_reg = !mem_read_i && !mem_write_i && !branch_i && (dest_i != 5'd0);
                st_d.dest       = dest_i;
                st_d.funct3     = funct3_i;
                st_d.bubble     = 1'b0;
                st_d.next_pc    = redirect ? target : pc_plus4;
                st_d.taken      = redirect;
                st_d.squash     = redirect;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q          <= '0;
            st_q.fetch_pc <= RESET;
        end else begin
            st_q <= st_d;
        end
    end

    assign fetch_pc_o         = st_q.fetch_pc;
    assign write_address_o    = st_q.addr;
    assign alu_operand2_o     = st_q.op2;
    assign mem_write_o        = st_q.mem_write;
    assign wb_mem_to_reg_o    = st_q.mem_to_reg;
    assign wb_alu_to_reg_o    = st_q.alu_to_reg;
    assign wb_dest_o          = st_q.dest;
    assign wb_read_address_o  = st_q.addr[1:0];
    assign wb_alu_operation_o = st_q.funct3;
    assign wb_branch_o        = st_q.bubble;
    assign next_pc_o          = st_q.next_pc;
    assign branch_taken_o     = st_q.taken;
    assign branch_stall_o     = st_q.squash;
endmodule

// File: tb/tb_execute.sv
// Directed bench for the execute stage: a vector table for single-cycle ops plus
// hand sequences for redirect, squash, stall and reset.
module tb_execute;
    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset, stall_i, valid_i;
    logic [31:0] pc_i, imm_i, rs1_data_i, rs2_data_i, fwd_data_i;
    logic [4:0]  rs1_i, rs2_i, dest_i, fwd_dest_i;
    logic [2:0]  funct3_i;
    logic        alt_i, imm_sel_i, lui_i, auipc_i, jal_i, jalr_i, branch_i;
    logic        mem_read_i, mem_write_i, fwd_we_i;
    logic [31:0] fetch_pc_o, write_address_o, alu_operand2_o, next_pc_o;
    logic        mem_write_o, wb_mem_to_reg_o, wb_alu_to_reg_o, wb_branch_o;
    logic [4:0]  wb_dest_o;
    logic [1:0]  wb_read_address_o;
    logic [2:0]  wb_alu_operation_o;
    logic        branch_taken_o, branch_stall_o;

    always #5 clk = ~clk;

    execute #(.RESET(RST_PC)) dut (
        .clk(clk), .reset(reset), .stall_i(stall_i), .valid_i(valid_i),
        .pc_i(pc_i), .imm_i(imm_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .funct3_i(funct3_i),
        .alt_i(alt_i), .imm_sel_i(imm_sel_i), .lui_i(lui_i), .auipc_i(auipc_i),
        .jal_i(jal_i), .jalr_i(jalr_i), .branch_i(branch_i),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .dest_i(dest_i),
        .fwd_we_i(fwd_we_i), .fwd_dest_i(fwd_dest_i), .fwd_data_i(fwd_data_i),
        .fetch_pc_o(fetch_pc_o), .write_address_o(write_address_o),
        .alu_operand2_o(alu_operand2_o), .mem_write_o(mem_write_o),
        .wb_mem_to_reg_o(wb_mem_to_reg_o), .wb_alu_to_reg_o(wb_alu_to_reg_o),
        .wb_dest_o(wb_dest_o), .wb_read_address_o(wb_read_address_o),
        .wb_alu_operation_o(wb_alu_operation_o), .wb_branch_o(wb_branch_o),
        .next_pc_o(next_pc_o), .branch_taken_o(branch_taken_o),
        .branch_stall_o(branch_stall_o)
    );

    typedef struct {
        logic [31:0] pc, imm, rs1d, rs2d, fdata;
        logic [4:0]  rs1, rs2, dest, fdest;
        logic [2:0]  f3;
        logic        alt, isel, lui, auipc, jal, jalr, br, mr, mw, fwe;
        logic        chk_addr;
        logic [31:0] e_addr, e_op2, e_npc;
        logic        e_mw, e_m2r, e_a2r;
    } vec_t;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t alu(input logic [2:0] f3, input logic alt,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic isel, input logic [31:0] imm,
                                 input logic [4:0] dest, input logic [31:0] exp);
        vec_t v;
        v.pc = 32'h100; v.imm = imm; v.rs1d = a; v.rs2d = b; v.fdata = 32'h0;
        v.rs1 = 5'd1; v.rs2 = 5'd2; v.dest = dest; v.fdest = 5'd0;
        v.f3 = f3; v.alt = alt; v.isel = isel;
        v.lui = 1'b0; v.auipc = 1'b0; v.jal = 1'b0; v.jalr = 1'b0; v.br = 1'b0;
        v.mr = 1'b0; v.mw = 1'b0; v.fwe = 1'b0; v.chk_addr = 1'b1;
        v.e_addr = exp; v.e_op2 = b; v.e_npc = 32'h104;
        v.e_mw = 1'b0; v.e_m2r = 1'b0; v.e_a2r = (dest != 5'd0);
        return v;
    endfunction

    function automatic vec_t brv(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        vec_t v;
        v = alu(f3, 1'b0, a, b, 1'b0, 32'h20, 5'd0, 32'h0);
        v.br = 1'b1; v.chk_addr = 1'b0;
        return v;
    endfunction

    task automatic idle();
        valid_i = 0; pc_i = 0; imm_i = 0; rs1_i = 0; rs2_i = 0; rs1_data_i = 0; rs2_data_i = 0;
        funct3_i = 0; alt_i = 0; imm_sel_i = 0; lui_i = 0; auipc_i = 0; jal_i = 0; jalr_i = 0;
        branch_i = 0; mem_read_i = 0; mem_write_i = 0; dest_i = 0;
        fwd_we_i = 0; fwd_dest_i = 0; fwd_data_i = 0;
    endtask

    task automatic drive(input vec_t v);
        valid_i = 1; pc_i = v.pc; imm_i = v.imm; rs1_i = v.rs1; rs2_i = v.rs2;
        rs1_data_i = v.rs1d; rs2_data_i = v.rs2d; funct3_i = v.f3; alt_i = v.alt;
        imm_sel_i = v.isel; lui_i = v.lui; auipc_i = v.auipc; jal_i = v.jal; jalr_i = v.jalr;
        branch_i = v.br; mem_read_i = v.mr; mem_write_i = v.mw; dest_i = v.dest;
        fwd_we_i = v.fwe; fwd_dest_i = v.fdest; fwd_data_i = v.fdata;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " fetch_pc"}, fetch_pc_o, RST_PC);
        chk({tag, " addr"}, write_address_o, 32'h0);
        chk({tag, " op2"}, alu_operand2_o, 32'h0);
        chk({tag, " next_pc"}, next_pc_o, 32'h0);
        chk({tag, " ctl"}, 32'({mem_write_o, wb_mem_to_reg_o, wb_alu_to_reg_o, wb_branch_o,
                               branch_taken_o, branch_stall_o}), 32'h0);
        chk({tag, " dest/op/lane"}, 32'({wb_dest_o, wb_alu_operation_o, wb_read_address_o}), 32'h0);
    endtask

    vec_t vt [23];
    vec_t v;

    initial begin
        vt[0]  = alu(3'd0, 1'b0, 32'd5, 32'd7, 1'b0, 32'd0, 5'd3, 32'd12);
        vt[1]  = alu(3'd0, 1'b1, 32'd5, 32'd7, 1'b0, 32'd0, 5'd3, 32'hFFFF_FFFE);
        vt[2]  = alu(3'd0, 1'b0, 32'd0, 32'd1, 1'b0, 32'd0, 5'd3, 32'hAB);
        vt[2].rs1 = 5'd5; vt[2].fwe = 1'b1; vt[2].fdest = 5'd5; vt[2].fdata = 32'hAA;
        vt[3]  = alu(3'd0, 1'b0, 32'd0, 32'd1, 1'b0, 32'd0, 5'd3, 32'd1);
        vt[3].rs1 = 5'd0; vt[3].fwe = 1'b1; vt[3].fdest = 5'd0; vt[3].fdata = 32'hAA;
        vt[4]  = alu(3'd0, 1'b0, 32'd3, 32'd0, 1'b0, 32'd0, 5'd4, 32'h23);
        vt[4].fwe = 1'b1; vt[4].fdest = 5'd2; vt[4].fdata = 32'h20; vt[4].e_op2 = 32'h20;
        vt[5]  = alu(3'd1, 1'b0, 32'd1, 32'd0, 1'b1, 32'd4, 5'd5, 32'h10);
        vt[6]  = alu(3'd2, 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 5'd5, 32'd1);
        vt[7]  = alu(3'd3, 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 5'd5, 32'd0);
        vt[8]  = alu(3'd4, 1'b0, 32'hF0F0, 32'h0FF0, 1'b0, 32'd0, 5'd6, 32'hFF00);
        vt[9]  = alu(3'd5, 1'b0, 32'h8000_0000, 32'd4, 1'b0, 32'd0, 5'd6, 32'h0800_0000);
        vt[10] = alu(3'd5, 1'b1, 32'h8000_0000, 32'd4, 1'b0, 32'd0, 5'd6, 32'hF800_0000);
        vt[11] = alu(3'd6, 1'b0, 32'hF0, 32'h0F, 1'b0, 32'd0, 5'd7, 32'hFF);
        vt[12] = alu(3'd7, 1'b0, 32'hF0, 32'h3C, 1'b0, 32'd0, 5'd7, 32'h30);
        vt[13] = alu(3'd0, 1'b0, 32'h999, 32'd0, 1'b1, 32'h1234_5000, 5'd8, 32'h1234_5000);
        vt[13].lui = 1'b1;
        vt[14] = alu(3'd0, 1'b0, 32'h999, 32'd0, 1'b1, 32'h10, 5'd8, 32'h110);
        vt[14].auipc = 1'b1;
        vt[15] = alu(3'd0, 1'b0, 32'h200, 32'hDEAD_BEEF, 1'b1, 32'd8, 5'd0, 32'h208);
        vt[15].mw = 1'b1; vt[15].e_mw = 1'b1;
        vt[16] = alu(3'd0, 1'b0, 32'h300, 32'd0, 1'b1, 32'd3, 5'd9, 32'h303);
        vt[16].mr = 1'b1; vt[16].e_m2r = 1'b1; vt[16].e_a2r = 1'b0;
        vt[17] = brv(3'd1, 32'd5, 32'd5);
        vt[18] = brv(3'd4, 32'd1, 32'hFFFF_FFFF);
        vt[19] = brv(3'd7, 32'd1, 32'hFFFF_FFFF);
        vt[20] = brv(3'd2, 32'd5, 32'd5);
        vt[21] = alu(3'd0, 1'b0, 32'd5, 32'd7, 1'b0, 32'd0, 5'd0, 32'd12);
        vt[22] = brv(3'd0, 32'd1, 32'd2);

        idle();
        stall_i = 0;
        reset = 1;
        tick(); tick();
        chk_reset("reset");
        reset = 0;

        foreach (vt[i]) begin
            drive(vt[i]);
            tick();
            if (vt[i].chk_addr) begin
                chk($sformatf("v%0d addr", i), write_address_o, vt[i].e_addr);
                chk($sformatf("v%0d lane", i), 32'(wb_read_address_o), 32'(vt[i].e_addr[1:0]));
            end
            chk($sformatf("v%0d op2", i), alu_operand2_o, vt[i].e_op2);
            chk($sformatf("v%0d next_pc", i), next_pc_o, vt[i].e_npc);
            chk($sformatf("v%0d fetch_pc", i), fetch_pc_o, vt[i].pc);
            chk($sformatf("v%0d taken/stall/bubble", i),
                32'({branch_taken_o, branch_stall_o, wb_branch_o}), 32'h0);
            chk($sformatf("v%0d mw", i), 32'(mem_write_o), 32'(vt[i].e_mw));
            chk($sformatf("v%0d m2r", i), 32'(wb_mem_to_reg_o), 32'(vt[i].e_m2r));
            chk($sformatf("v%0d a2r", i), 32'(wb_alu_to_reg_o), 32'(vt[i].e_a2r));
            chk($sformatf("v%0d dest", i), 32'(wb_dest_o), 32'(vt[i].dest));
            chk($sformatf("v%0d aluop", i), 32'(wb_alu_operation_o), 32'(vt[i].f3));
        end

        // Plain bubble after a load: controls drop, not marked as squashed.
        drive(vt[16]); tick();
        idle(); tick();
        chk("bubble ctl", 32'({mem_write_o, wb_mem_to_reg_o, wb_alu_to_reg_o, wb_branch_o,
                              branch_taken_o}), 32'h0);

        // beq taken, then the wrong-path store is squashed, then accepted.
        v = brv(3'd0, 32'd3, 32'd3); v.pc = 32'h40; v.imm = 32'h10;
        drive(v); tick();
        chk("beq taken", 32'(branch_taken_o), 32'd1);
        chk("beq next_pc", next_pc_o, 32'h50);
        chk("beq stall", 32'(branch_stall_o), 32'd1);
        chk("beq fetch_pc", fetch_pc_o, 32'h40);
        v = alu(3'd0, 1'b0, 32'h200, 32'h55, 1'b1, 32'd8, 5'd0, 32'h208); v.mw = 1'b1;
        drive(v); tick();
        chk("squash bubble", 32'(wb_branch_o), 32'd1);
        chk("squash mw", 32'(mem_write_o), 32'd0);
        chk("squash taken/stall", 32'({branch_taken_o, branch_stall_o}), 32'd0);
        tick();
        chk("post-squash mw", 32'(mem_write_o), 32'd1);
        chk("post-squash bubble", 32'(wb_branch_o), 32'd0);
        chk("post-squash addr", write_address_o, 32'h208);

        // jalr: target clears bit 0, link is pc+4.
        v = alu(3'd0, 1'b0, 32'h101, 32'd0, 1'b1, 32'd4, 5'd1, 32'h24);
        v.jalr = 1'b1; v.pc = 32'h20;
        drive(v); tick();
        chk("jalr next_pc", next_pc_o, 32'h104);
        chk("jalr link", write_address_o, 32'h24);
        chk("jalr taken/stall", 32'({branch_taken_o, branch_stall_o}), 32'h3);
        chk("jalr a2r", 32'(wb_alu_to_reg_o), 32'd1);
        idle(); tick();
        chk("jalr squash", 32'({wb_branch_o, wb_alu_to_reg_o}), 32'h2);

        // jal with a negative offset.
        v = alu(3'd0, 1'b0, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFF8, 5'd1, 32'h204);
        v.jal = 1'b1; v.pc = 32'h200;
        drive(v); tick();
        chk("jal next_pc", next_pc_o, 32'h1F8);
        chk("jal link", write_address_o, 32'h204);
        idle(); tick();

        // blt taken on signed operands.
        v = brv(3'd4, 32'hFFFF_FFFF, 32'd1); v.pc = 32'h60; v.imm = 32'h8;
        drive(v); tick();
        chk("blt taken", 32'(branch_taken_o), 32'd1);
        chk("blt next_pc", next_pc_o, 32'h68);
        idle(); tick();

        // Stall for 3 cycles inside the squash window.
        v = brv(3'd0, 32'd9, 32'd9); v.pc = 32'h40; v.imm = 32'h10;
        drive(v); tick();
        stall_i = 1;
        v = alu(3'd0, 1'b0, 32'd1, 32'd1, 1'b0, 32'd0, 5'd2, 32'd2); v.pc = 32'h44;
        drive(v);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("stall%0d taken/stall/bubble", c),
                32'({branch_taken_o, branch_stall_o, wb_branch_o}), 32'h6);
            chk($sformatf("stall%0d next_pc", c), next_pc_o, 32'h50);
            chk($sformatf("stall%0d fetch_pc", c), fetch_pc_o, 32'h40);
        end
        stall_i = 0;
        tick();
        chk("stall release squash", 32'({branch_taken_o, branch_stall_o, wb_branch_o}), 32'h1);
        chk("stall release a2r", 32'(wb_alu_to_reg_o), 32'd0);

        // Stall holds a normal result.
        drive(vt[0]); tick();
        stall_i = 1; rs1_data_i = 32'd100; tick();
        chk("stall hold addr", write_address_o, 32'd12);
        stall_i = 0; tick();
        chk("stall resume addr", write_address_o, 32'd107);

        // Reset during a taken branch, with stall also high.
        v = brv(3'd0, 32'd3, 32'd3); v.pc = 32'h40; v.imm = 32'h10;
        drive(v); tick();
        chk("pre-reset taken", 32'(branch_taken_o), 32'd1);
        reset = 1; stall_i = 1; tick();
        chk_reset("mid reset");
        reset = 0; stall_i = 0; idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
